// File: rtl/sipo_loader.sv
// Serial-to-parallel loader: assembles an n-bit MSB-first word plus an even-parity bit,
// then presents it on d with a one-cycle load strobe (or a perr strobe on a bad frame).
module sipo_loader #(
  parameter int unsigned n = 4
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         sin,
  input  logic         sin_valid,
  output logic [n-1:0] d,
  output logic         load,
  output logic         perr,
  output logic         busy
);

  localparam int unsigned CW = $clog2(n) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [n-1:0]    sh;
  logic [n-1:0]    sh_nxt;
  logic [n-1:0]    d_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   cnt_inc;
  logic            load_nxt;
  logic            perr_nxt;

  // State and registered outputs
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      d     <= '0;
      load  <= 1'b0;
      perr  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      cnt   <= cnt_nxt;
      d     <= d_nxt;
      load  <= load_nxt;
      perr  <= perr_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Next-state and next-output logic; everything holds while sin_valid is low
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    d_nxt     = d;
    load_nxt  = 1'b0;
    perr_nxt  = 1'b0;
    cnt_inc   = cnt + CW'(1);

    if (sin_valid) begin
      case (state)
        IDLE: begin
          sh_nxt    = n'({sh, sin});
          cnt_nxt   = CW'(1);
          state_nxt = (n == 1) ? PAR : DATA;
        end
        DATA: begin
          sh_nxt  = n'({sh, sin});
          cnt_nxt = cnt_inc;
          if (cnt_inc == CW'(n)) begin
            state_nxt = PAR;
          end
        end
        PAR: begin
          // Even parity across data and parity bit
          if (^{sh, sin} == 1'b0) begin
            d_nxt    = sh;
            load_nxt = 1'b1;
          end else begin
            perr_nxt = 1'b1;
          end
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_loader.sv
// Self-checking bench for sipo_loader: directed frames then randomized frames with gaps,
// compared against a bit-count/word-value reference model and a negedge capture register.
module tb_sipo_loader;

  localparam int unsigned N = 4;

  logic         ck = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic [N-1:0] d;
  logic         load;
  logic         perr;
  logic         busy;

  sipo_loader #(.n(N)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_valid (sin_valid),
    .d         (d),
    .load      (load),
    .perr      (perr),
    .busy      (busy)
  );

  always #5 ck = ~ck;

  // Downstream register fed by the DUT, capturing on negedge
  logic [N-1:0] reg_q = '0;
  always @(negedge ck) if (load) reg_q <= d;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int           m_nbits = 0;
  int           m_word  = 0;
  logic [N-1:0] m_d     = '0;
  logic         m_load  = 1'b0;
  logic         m_perr  = 1'b0;
  logic         m_busy  = 1'b0;
  logic [N-1:0] m_reg   = '0;
  logic         prev_load = 1'b0;
  int           load_cycle = 0;
  int           cycle = 0;
  int           last_load_cycle = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle, got, exp);
    end
  endtask

  task automatic model_clk(input logic v, input logic b);
    int ones;
    m_load = 1'b0;
    m_perr = 1'b0;
    if (v) begin
      if (m_nbits < N) begin
        m_word  = (m_word * 2 + int'(b)) % (1 << N);
        m_nbits = m_nbits + 1;
        m_busy  = 1'b1;
      end else begin
        ones = $countones(N'(m_word)) + int'(b);
        if (ones % 2 == 0) begin
          m_d    = N'(m_word);
          m_load = 1'b1;
        end else begin
          m_perr = 1'b1;
        end
        m_nbits = 0;
        m_busy  = 1'b0;
      end
    end
  endtask

  // One clock: drive inputs, check outputs #1 after posedge, check register after negedge
  task automatic step(input logic v, input logic b);
    sin_valid = v;
    sin       = b;
    @(posedge ck);
    cycle++;
    model_clk(v, b);
    #1;
    check("d", 32'(d), 32'(m_d));
    check("load", 32'(load), 32'(m_load));
    check("perr", 32'(perr), 32'(m_perr));
    check("busy", 32'(busy), 32'(m_busy));
    check("load_perr_excl", 32'(load & perr), 32'd0);
    check("load_b2b", 32'(prev_load & load), 32'd0);
    prev_load = load;
    if (load) begin
      last_load_cycle = load_cycle;
      load_cycle      = cycle;
    end
    @(negedge ck);
    if (m_load) m_reg = m_d;
    #1;
    check("reg_q", 32'(reg_q), 32'(m_reg));
  endtask

  task automatic send_frame(input logic [N-1:0] w, input logic p, input int gap_at, input int gap_len);
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) step(1'b0, 1'($urandom));
      end
      step(1'b1, w[N-1-i]);
    end
    step(1'b1, p);
  endtask

  task automatic model_reset();
    m_nbits = 0;
    m_word  = 0;
    m_d     = '0;
    m_load  = 1'b0;
    m_perr  = 1'b0;
    m_busy  = 1'b0;
    prev_load = 1'b0;
  endtask

  initial begin
    logic [N-1:0] w;
    logic         good;
    int           gap_at;
    int           gap_len;

    // Reset state
    repeat (2) @(negedge ck);
    #1;
    check("rst_d", 32'(d), 32'd0);
    check("rst_load", 32'(load), 32'd0);
    check("rst_perr", 32'(perr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Good frame 0001/p1
    send_frame(4'b0001, 1'b1, -1, 0);
    check("f1_d", 32'(d), 32'h1);
    check("f1_reg", 32'(reg_q), 32'h1);
    step(1'b0, 1'b0);
    check("f1_load_fall", 32'(load), 32'd0);

    // Bad frame 0010/p0: d holds
    send_frame(4'b0010, 1'b0, -1, 0);
    check("f2_perr", 32'(perr), 32'd1);
    check("f2_d_hold", 32'(d), 32'h1);

    // 0011/p0 with a 3-cycle gap before the 3rd bit
    send_frame(4'b0011, 1'b0, 2, 3);
    check("f3_d", 32'(d), 32'h3);

    // Back-to-back 0010/p1 then 0100/p1: loads 5 cycles apart
    send_frame(4'b0010, 1'b1, -1, 0);
    check("f4_d", 32'(d), 32'h2);
    send_frame(4'b0100, 1'b1, -1, 0);
    check("f5_d", 32'(d), 32'h4);
    check("b2b_spacing", 32'(load_cycle - last_load_cycle), 32'd5);

    // Asynchronous reset mid-frame after 2 bits
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    sin_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_d", 32'(d), 32'd0);
    check("arst_load", 32'(load), 32'd0);
    check("arst_perr", 32'(perr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge ck);
    #1;
    rst_n = 1'b1;
    send_frame(4'b0101, 1'b0, -1, 0);
    check("f6_d", 32'(d), 32'h5);
    check("f6_load", 32'(load), 32'd1);

    // Bad frame then immediately good 1111/p0
    send_frame(4'b1000, 1'b0, -1, 0);
    check("f7_perr", 32'(perr), 32'd1);
    send_frame(4'b1111, 1'b0, -1, 0);
    check("f8_d", 32'(d), 32'hf);

    // Randomized frames with random gaps and parity errors
    for (int f = 0; f < 200; f++) begin
      w       = N'($urandom);
      good    = ($urandom % 4) != 0;
      gap_at  = ($urandom % 3 == 0) ? int'($urandom % (N + 1)) : -1;
      gap_len = 1 + int'($urandom % 3);
      send_frame(w, good ? ^w : ~^w, gap_at, gap_len);
      if ($urandom % 4 == 0) step(1'b0, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout cycle=%0d got=running exp=finished", cycle);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
